// File: rtl/nm_bus_master_if.sv
// Command/response port and nm parallel bus bundle for nm_bus_master.
// master = sequencer side, slave = host + nm array side.
interface nm_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [3:0]  cmd_reg;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_timeout;
  logic        busy;
  logic        CS_l;
  logic        DS;
  logic        RW_l;
  logic [3:0]  REG;
  logic [15:0] DATA_O;
  logic        DATA_OE;
  logic [15:0] DATA_I;
  logic        RDY;

  modport master (
    input  cmd_valid, cmd_rw, cmd_reg, cmd_wdata,
    input  DATA_I, RDY,
    output cmd_ready, rsp_valid, rsp_rdata,
    output rsp_timeout, busy,
    output CS_l, DS, RW_l, REG, DATA_O, DATA_OE
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_reg, cmd_wdata,
    output DATA_I, RDY,
    input  cmd_ready, rsp_valid, rsp_rdata,
    input  rsp_timeout, busy,
    input  CS_l, DS, RW_l, REG, DATA_O, DATA_OE
  );
endinterface

// File: rtl/nm_bus_master.sv
// Host-side sequencer: queues nm register commands in a FIFO and runs
// them one at a time on the nm bus (CS_l/DS/RW_l/REG/DATA), waiting on RDY.
// Ports: G_CLK, reset_l (async, active-low), bus (nm_bus_master_if.master).
module nm_bus_master #(
  parameter int FIFO_DEPTH  = 4,
  parameter int DS_CYCLES   = 1,
  parameter int RDY_TIMEOUT = 1023
) (
  input  logic G_CLK,
  input  logic reset_l,
  nm_bus_master_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(RDY_TIMEOUT + 1);
  localparam int DW = (DS_CYCLES > 1) ? $clog2(DS_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, WAIT_RDY, RESP
  } state_t;

  typedef struct packed {
    logic        rw;
    logic [3:0]  rg;
    logic [15:0] wdata;
  } cmd_t;

  cmd_t          mem_q [FIFO_DEPTH];
  cmd_t          mem_d [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic          cmd_ready_q, cmd_ready_d;

  state_t        state_q, state_d;
  logic [DW-1:0] dsc_q, dsc_d;
  logic [CW-1:0] wc_q, wc_d;
  logic          cs_l_q, cs_l_d;
  logic          ds_q, ds_d;
  logic          rw_l_q, rw_l_d;
  logic [3:0]    reg_q, reg_d;
  logic [15:0]   data_o_q, data_o_d;
  logic          data_oe_q, data_oe_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [15:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic          busy_q, busy_d;

  logic push, pop;
  cmd_t head;

  assign push = bus.cmd_valid & cmd_ready_q;
  assign head = mem_q[rptr_q];

  always_comb begin
    mem_d         = mem_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    fill_d        = fill_q;
    state_d       = state_q;
    dsc_d         = dsc_q;
    wc_d          = wc_q;
    cs_l_d        = cs_l_q;
    ds_d          = ds_q;
    rw_l_d        = rw_l_q;
    reg_d         = reg_q;
    data_o_d      = data_o_q;
    data_oe_d     = data_oe_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;
    pop           = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fill_q != '0 && bus.RDY) begin
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        ds_d    = 1'b1;
        dsc_d   = '0;
        state_d = STROBE;
      end
      STROBE: begin
        if (dsc_q == DW'(DS_CYCLES - 1)) begin
          ds_d      = 1'b0;
          data_oe_d = 1'b0;
          wc_d      = '0;
          state_d   = WAIT_RDY;
        end else begin
          dsc_d = dsc_q + 1'b1;
        end
      end
      WAIT_RDY: begin
        if (bus.RDY) begin
          // RW_l is still the access direction here: 1 = read
          rsp_rdata_d   = rw_l_q ? bus.DATA_I : '0;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (wc_q == CW'(RDY_TIMEOUT)) begin
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else begin
          wc_d = wc_q + 1'b1;
        end
      end
      RESP: begin
        if (fill_q != '0 && bus.RDY) begin
          pop     = 1'b1;
          state_d = SETUP;
        end else begin
          cs_l_d  = 1'b1;
          rw_l_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Back-to-back pops from RESP keep CS_l low
    if (pop) begin
      cs_l_d    = 1'b0;
      reg_d     = head.rg;
      rw_l_d    = head.rw;
      data_o_d  = head.wdata;
      data_oe_d = ~head.rw;
      rptr_d    = rptr_q + 1'b1;
    end

    if (push) begin
      mem_d[wptr_q] = '{bus.cmd_rw, bus.cmd_reg,
                        bus.cmd_wdata};
      wptr_d = wptr_q + 1'b1;
    end

    unique case (1'b1)
      push && !pop: fill_d = fill_q + 1'b1;
      pop && !push: fill_d = fill_q - 1'b1;
      default:      fill_d = fill_q;
    endcase

    cmd_ready_d = (fill_d != (AW+1)'(FIFO_DEPTH));
    busy_d      = (state_d != IDLE) || (fill_d != '0);
  end

  always_ff @(posedge G_CLK or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      fill_q        <= '0;
      cmd_ready_q   <= 1'b0;
      state_q       <= IDLE;
      dsc_q         <= '0;
      wc_q          <= '0;
      cs_l_q        <= 1'b1;
      ds_q          <= 1'b0;
      rw_l_q        <= 1'b1;
      reg_q         <= '0;
      data_o_q      <= '0;
      data_oe_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      fill_q        <= fill_d;
      cmd_ready_q   <= cmd_ready_d;
      state_q       <= state_d;
      dsc_q         <= dsc_d;
      wc_q          <= wc_d;
      cs_l_q        <= cs_l_d;
      ds_q          <= ds_d;
      rw_l_q        <= rw_l_d;
      reg_q         <= reg_d;
      data_o_q      <= data_o_d;
      data_oe_q     <= data_oe_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.busy        = busy_q;
  assign bus.CS_l        = cs_l_q;
  assign bus.DS          = ds_q;
  assign bus.RW_l        = rw_l_q;
  assign bus.REG         = reg_q;
  assign bus.DATA_O      = data_o_q;
  assign bus.DATA_OE     = data_oe_q;
endmodule
